// File: rtl/load_dff_serializer_if.sv
// Handshake and serial-output bundle between a word producer, the serializer
// and the downstream load-enabled flop.
interface load_dff_serializer_if #(
  parameter int W = 8
) ();
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         a;
  logic         sel;
  logic         busy;
  logic         last;

  modport master (
    output din,
    output din_valid,
    input  din_ready,
    input  a,
    input  sel,
    input  busy,
    input  last
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready,
    output a,
    output sel,
    output busy,
    output last
  );
endinterface

// File: rtl/load_dff_serializer.sv
// Serialises parallel words one bit per clock onto a load-enabled flop.
// sel=0 makes the flop load `a`; sel=1 makes it hold.
module load_dff_serializer #(
  parameter int W         = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  load_dff_serializer_if.slave  bus
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    sreg_q, sreg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            a_q, a_d;
  logic            sel_q, sel_d;
  logic            busy_q, busy_d;
  logic            last_q, last_d;
  logic            ready_s;
  logic            take_s;

  function automatic logic head_bit(input logic [W-1:0] w);
    return LSB_FIRST ? w[0] : w[W-1];
  endfunction

  // The register keeps only the bits not yet presented on `a`.
  function automatic logic [W-1:0] advance(input logic [W-1:0] w);
    return LSB_FIRST ? (w >> 1) : (w << 1);
  endfunction

  assign ready_s       = (state_q == IDLE) || last_q;
  assign take_s        = bus.din_valid && ready_s;
  assign bus.din_ready = ready_s;
  assign bus.a         = a_q;
  assign bus.sel       = sel_q;
  assign bus.busy      = busy_q;
  assign bus.last      = last_q;

  // State and output registers; rst overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= {W{1'b0}};
      cnt_q   <= {CW{1'b0}};
      a_q     <= 1'b0;
      sel_q   <= 1'b1;
      busy_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
    end
  end

  // Next state: capture a word, shift the next bit, or fall back to idle.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    last_d  = last_q;

    case (state_q)
      IDLE, SHIFT: begin
        if (take_s) begin
          state_d = SHIFT;
          a_d     = head_bit(bus.din);
          sreg_d  = advance(bus.din);
          cnt_d   = CW'(W - 1);
          sel_d   = 1'b0;
          busy_d  = 1'b1;
          last_d  = 1'b0;
        end else if ((state_q == SHIFT) && !last_q) begin
          state_d = SHIFT;
          a_d     = head_bit(sreg_q);
          sreg_d  = advance(sreg_q);
          cnt_d   = cnt_q - CW'(1);
          sel_d   = 1'b0;
          busy_d  = 1'b1;
          last_d  = (cnt_q == CW'(1));
        end else begin
          state_d = IDLE;
          a_d     = 1'b0;
          sel_d   = 1'b1;
          busy_d  = 1'b0;
          last_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        sreg_d  = {W{1'b0}};
        cnt_d   = {CW{1'b0}};
        a_d     = 1'b0;
        sel_d   = 1'b1;
        busy_d  = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_load_dff_serializer.sv
// Directed bench: an MSB-first and an LSB-first W=4 serializer, with a
// bench-side load flop fed by the MSB-first instance.
module tb_load_dff_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic q_m   = 1'b0;

  load_dff_serializer_if #(.W(4)) m_if ();
  load_dff_serializer_if #(.W(4)) l_if ();

  load_dff_serializer #(.W(4), .LSB_FIRST(1'b0)) u_msb (
    .clk (clk),
    .rst (rst),
    .bus (m_if.slave)
  );

  load_dff_serializer #(.W(4), .LSB_FIRST(1'b1)) u_lsb (
    .clk (clk),
    .rst (rst),
    .bus (l_if.slave)
  );

  always #5 clk = ~clk;

  // Model of the downstream load-enabled flop.
  always @(posedge clk) begin
    if (!m_if.sel) q_m <= m_if.a;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_a"},     8'(m_if.a),         8'h00);
    chk({tag, "_sel"},   8'(m_if.sel),       8'h01);
    chk({tag, "_busy"},  8'(m_if.busy),      8'h00);
    chk({tag, "_last"},  8'(m_if.last),      8'h00);
    chk({tag, "_ready"}, 8'(m_if.din_ready), 8'h01);
  endtask

  // Word w0, then w1 raised when the stream reaches index w1_at; exp is the
  // expected 8-bit stream, first bit in exp[7].
  task automatic two_words(input string tag, input logic [3:0] w0, input logic [3:0] w1,
                           input int w1_at, input logic [7:0] exp);
    m_if.din = w0;
    m_if.din_valid = 1'b1;
    tick();
    m_if.din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      if (i == 4) m_if.din_valid = 1'b0;
      chk($sformatf("%s_a%0d", tag, i),    8'(m_if.a),         8'(exp[7-i]));
      chk($sformatf("%s_sel%0d", tag, i),  8'(m_if.sel),       8'h00);
      chk($sformatf("%s_busy%0d", tag, i), 8'(m_if.busy),      8'h01);
      chk($sformatf("%s_last%0d", tag, i), 8'(m_if.last),      ((i == 3) || (i == 7)) ? 8'h01 : 8'h00);
      chk($sformatf("%s_rdy%0d", tag, i),  8'(m_if.din_ready), ((i == 3) || (i == 7)) ? 8'h01 : 8'h00);
      if (i == w1_at) begin
        m_if.din = w1;
        m_if.din_valid = 1'b1;
      end
    end
    tick();
    chk_idle({tag, "_end"});
  endtask

  initial begin
    logic [3:0] bits;

    // Reset with a valid word offered: nothing may be captured.
    m_if.din = 4'b1011;
    m_if.din_valid = 1'b1;
    l_if.din = 4'b0000;
    l_if.din_valid = 1'b0;
    tick();
    tick();
    chk_idle("rst");
    rst = 1'b0;
    m_if.din_valid = 1'b0;
    tick();
    chk_idle("rst_nocap");

    // Single word 1011, MSB first, plus the flop output.
    bits = 4'b1011;
    m_if.din = bits;
    m_if.din_valid = 1'b1;
    tick();
    m_if.din_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      chk($sformatf("one_a%0d", i),    8'(m_if.a),    8'(bits[3-i]));
      chk($sformatf("one_sel%0d", i),  8'(m_if.sel),  8'h00);
      chk($sformatf("one_last%0d", i), 8'(m_if.last), (i == 3) ? 8'h01 : 8'h00);
      if (i > 0) chk($sformatf("one_q%0d", i), 8'(q_m), 8'(bits[4-i]));
    end
    tick();
    chk_idle("one_end");
    chk("one_q_last", 8'(q_m), 8'h01);
    tick();
    chk("one_q_hold", 8'(q_m), 8'h01);

    // Back-to-back: second word offered during last.
    two_words("b2b", 4'b1100, 4'b0011, 3, 8'b1100_0011);

    // Ready gating: 1111 offered at cnt=2 and held until accepted.
    two_words("gate", 4'b0101, 4'b1111, 1, 8'b0101_1111);

    // LSB-first instance.
    bits = 4'b0001;
    l_if.din = bits;
    l_if.din_valid = 1'b1;
    tick();
    l_if.din_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      chk($sformatf("lsb_a%0d", i),    8'(l_if.a),    8'(bits[i]));
      chk($sformatf("lsb_sel%0d", i),  8'(l_if.sel),  8'h00);
      chk($sformatf("lsb_last%0d", i), 8'(l_if.last), (i == 3) ? 8'h01 : 8'h00);
    end
    tick();
    chk("lsb_end_sel", 8'(l_if.sel), 8'h01);
    chk("lsb_end_a",   8'(l_if.a),   8'h00);

    // Reset on the edge that would present the 2nd bit of 1010.
    m_if.din = 4'b1010;
    m_if.din_valid = 1'b1;
    tick();
    m_if.din_valid = 1'b0;
    chk("mid_a0", 8'(m_if.a), 8'h01);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("mid_rst");
    chk("mid_q", 8'(q_m), 8'h01);
    tick();
    chk_idle("mid_after");
    chk("mid_q_hold", 8'(q_m), 8'h01);

    // Next word after reset.
    bits = 4'b0110;
    m_if.din = bits;
    m_if.din_valid = 1'b1;
    tick();
    m_if.din_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      chk($sformatf("post_a%0d", i),    8'(m_if.a),    8'(bits[3-i]));
      chk($sformatf("post_last%0d", i), 8'(m_if.last), (i == 3) ? 8'h01 : 8'h00);
    end
    tick();
    chk_idle("post_end");
    chk("post_q", 8'(q_m), 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
